i2c_master_ctrl: RTL and testbench
==================================

# i2c_master_ctrl

Single-master I2C write controller that sequences the bus for the LED-slave path. It accepts one write request (7-bit address plus one data byte) on a valid/ready handshake. It then generates START, the address byte with R/W=0, address ACK check, the data byte, data ACK check and STOP on SCL/SDA, and reports completion and ACK status. It sits between the system-side command logic and the board-level SCL/SDA lines, in front of the slave at address 0x55.

## Interface
Parameters:
- CLK_DIV, default 25: clk cycles per SCL quarter-period; legal values are 2 and above; one SCL bit = 4*CLK_DIV cycles.
- MAX_RETRY, default 3: extra attempts after a NACK; used only when I2C_NACK_RETRY_EN is defined.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  input  1  request present.
- req_ready  output  1  high in IDLE; the transfer is accepted on req_valid & req_ready.
- req_addr  input  7  slave address, captured at accept.
- req_data  input  8  data byte, captured at accept.
- busy  output  1  high from the cycle after accept until done.
- done  output  1  one-cycle pulse at the end of the transaction.
- nack  output  1  valid with done; 1 = address or data NACK; held until the next accept.
- SCL  output  1  push-pull bus clock.
- SDA  inout  1  open-drain; the block drives 0 or releases to 1'bz, never drives 1.

## Operation
States and transitions:
- IDLE → START on accept.
- START → ADDR → AACK.
- AACK → DATA if ACK, otherwise → STOP with the nack flag set.
- DATA → DACK → STOP.
- STOP → IDLE.

Datapath and counters:
- Shift register is loaded with {req_addr,1'b0} at accept, then with req_data on entering DATA. Bits are sent MSB first; a 3-bit counter covers 0..7.
- Each state except IDLE lasts one phase of four quarters, Q0..Q3, each CLK_DIV cycles long. The tick counter is $clog2(CLK_DIV) bits wide and wraps at CLK_DIV-1.

Pin levels per quarter (SCL / SDA):
- START: Q0 1/Z, Q1 1/0, Q2 1/0, Q3 0/0.
- ADDR and DATA bits: Q0 0/bit, Q1 1/bit, Q2 1/bit, Q3 0/bit. A bit value of 1 means SDA is released.
- AACK and DACK: SDA released in all quarters; SCL as for bits; SDA sampled on the last cycle of Q2. Sample 0 = ACK, 1 = NACK.
- STOP: Q0 0/0, Q1 1/0, Q2 1/Z, Q3 1/Z.

Completion:
- On STOP exit: done=1 for one cycle, busy=0, return to IDLE, req_ready=1.

Boundary conditions:
- req_valid while busy is ignored, and input changes are ignored after capture.
- A NACK on the address skips DATA/DACK entirely.
- Asserting reset mid-transfer immediately releases SDA and sets SCL=1. Any partial transfer is abandoned; no done pulse is produced.
- Back-to-back requests: an accept is possible in the cycle after done.

## Timing
- Reset values: SCL=1, SDA=Z, req_ready=1, busy=0, done=0, nack=0.
- An accept in cycle T makes the first START phase begin at T+1.
- A full ACKed transaction is 20 phases: START 1, ADDR 8, AACK 1, DATA 8, DACK 1, STOP 1. done pulses at T+1+80*CLK_DIV.
- An address-NACK transaction is 11 phases: done pulses at T+1+44*CLK_DIV.
- SDA changes only in Q0 while SCL is low, except for the START and STOP edges.

## Configuration
- I2C_NACK_RETRY_EN defined:
  - After the STOP of a NACKed attempt, if the retry count < MAX_RETRY, the block returns to START with no done pulse and busy held high.
  - The retry counter is cleared at accept.
  - done with nack=1 is produced only after MAX_RETRY+1 failed attempts; a later ACKed attempt gives done with nack=0.
- Not defined: no retry; MAX_RETRY is ignored; every NACK ends the transaction.

## Test plan
- Reset release with CLK_DIV=2: SCL=1, SDA=Z, req_ready=1, busy=0 → accept addr 0x55, data 0xA5 with the 0x55 slave model → done at T+161, nack=0, slave LED=0xA5.
- Addr 0x12, no device → SDA reads 1 at AACK → DATA skipped, done at T+89, nack=1.
- Slave model NACKs data 0x3C → full 20 phases, done at T+161, nack=1.
- Bus monitor over the 0x55/0xA5 transfer → START (SDA falls while SCL=1) observed, serial bits 1010101 0 then 10100101, STOP observed, SDA never driven to 1.
- reset pulled low in the middle of DATA → same cycle SCL=1, SDA=Z; no done pulse; the next request completes normally.
- I2C_NACK_RETRY_EN with MAX_RETRY=3 and address 0x12 → 4 attempts, one done with nack=1. Slave ACKing on the 2nd attempt → done with nack=0.

Source files
------------

// File: rtl/i2c_master_ctrl_if.sv
// Request/status bundle between the command logic (master) and i2c_master_ctrl (slave).
interface i2c_master_ctrl_if;
  logic       req_valid;
  logic       req_ready;
  logic [6:0] req_addr;
  logic [7:0] req_data;
  logic       busy;
  logic       done;
  logic       nack;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, busy, done, nack
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, busy, done, nack
  );
endinterface

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C write master: START, addr+W, ACK, data, ACK, STOP.
// Define I2C_NACK_RETRY_EN to re-run NACKed attempts up to MAX_RETRY times.
//
// state   | meaning
// S_IDLE  | bus idle, request accepted here
// S_START | START condition phase
// S_ADDR  | 8 bit phases of {addr,W}
// S_AACK  | address acknowledge slot
// S_DATA  | 8 bit phases of the data byte
// S_DACK  | data acknowledge slot
// S_STOP  | STOP condition phase
module i2c_master_ctrl #(
  parameter int CLK_DIV   = 25,
  parameter int MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             reset,
  i2c_master_ctrl_if.slave req,
  output logic             SCL,
  inout  wire              SDA
);
  localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_ADDR, S_AACK, S_DATA, S_DACK, S_STOP
  } state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] tick;
  logic [1:0]    quarter;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic [6:0]    addr_q;
  logic [7:0]    data_q;
  logic          ack_smp;
  logic          att_nack;
  logic          nack_q;
  logic          done_q;
  logic          sda_low;
  logic          accept;
  logic          phase_end;
  logic          restart;

  assign accept    = req.req_valid & req.req_ready;
  assign phase_end = (tick == TICK_LAST) && (quarter == 2'd3);

`ifdef I2C_NACK_RETRY_EN
  localparam int RW = $clog2(MAX_RETRY + 2);
  logic [RW-1:0] retry_cnt;

  assign restart = att_nack && (retry_cnt < RW'(MAX_RETRY));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retry_cnt <= '0;
    end else if (accept) begin
      retry_cnt <= '0;
    end else if (state == S_STOP && phase_end && restart) begin
      retry_cnt <= retry_cnt + 1'b1;
    end
  end
`else
  // MAX_RETRY has no effect without retry support.
  wire unused_max_retry = (MAX_RETRY != 0);
  assign restart = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    SCL       = 1'b1;
    sda_low   = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) state_nxt = S_START;
      end
      S_START: begin
        SCL     = (quarter != 2'd3);
        sda_low = (quarter != 2'd0);
        if (phase_end) state_nxt = S_ADDR;
      end
      S_ADDR, S_DATA: begin
        SCL     = (quarter == 2'd1) || (quarter == 2'd2);
        sda_low = ~shift[7];
        if (phase_end && bit_cnt == 3'd7)
          state_nxt = (state == S_ADDR) ? S_AACK : S_DACK;
      end
      S_AACK: begin
        SCL = (quarter == 2'd1) || (quarter == 2'd2);
        if (phase_end) state_nxt = ack_smp ? S_STOP : S_DATA;
      end
      S_DACK: begin
        SCL = (quarter == 2'd1) || (quarter == 2'd2);
        if (phase_end) state_nxt = S_STOP;
      end
      S_STOP: begin
        SCL     = (quarter != 2'd0);
        sda_low = (quarter == 2'd0) || (quarter == 2'd1);
        if (phase_end) state_nxt = restart ? S_START : S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick     <= '0;
      quarter  <= 2'd0;
      bit_cnt  <= 3'd0;
      shift    <= 8'd0;
      addr_q   <= 7'd0;
      data_q   <= 8'd0;
      ack_smp  <= 1'b0;
      att_nack <= 1'b0;
      nack_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == S_IDLE) begin
        tick    <= '0;
        quarter <= 2'd0;
      end else begin
        tick <= (tick == TICK_LAST) ? '0 : tick + 1'b1;
        if (tick == TICK_LAST) quarter <= quarter + 2'd1;
      end
      if (accept) begin
        addr_q   <= req.req_addr;
        data_q   <= req.req_data;
        shift    <= {req.req_addr, 1'b0};
        bit_cnt  <= 3'd0;
        att_nack <= 1'b0;
        nack_q   <= 1'b0;
      end
      // Slave drives the ACK bit; sample it at the end of the SCL-high window.
      if ((state == S_AACK || state == S_DACK) && quarter == 2'd2 && tick == TICK_LAST)
        ack_smp <= SDA;
      if (phase_end) begin
        case (state)
          S_ADDR, S_DATA: begin
            shift   <= {shift[6:0], 1'b0};
            bit_cnt <= bit_cnt + 3'd1;
          end
          S_AACK: begin
            if (ack_smp) att_nack <= 1'b1;
            else         shift    <= data_q;
          end
          S_DACK: begin
            if (ack_smp) att_nack <= 1'b1;
          end
          S_STOP: begin
            if (restart) begin
              shift    <= {addr_q, 1'b0};
              att_nack <= 1'b0;
            end else begin
              done_q <= 1'b1;
              nack_q <= att_nack;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign SDA           = sda_low ? 1'b0 : 1'bz;
  assign req.req_ready = (state == S_IDLE);
  assign req.busy      = (state != S_IDLE);
  assign req.done      = done_q;
  assign req.nack      = nack_q;
endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Scoreboard bench for i2c_master_ctrl with an I2C slave model at address 0x55.
module tb_i2c_master_ctrl;
  localparam int CD = 2;
  localparam int MR = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic SCL;
  wire  SDA;
  i2c_master_ctrl_if rq();

  i2c_master_ctrl #(.CLK_DIV(CD), .MAX_RETRY(MR)) dut (
    .clk   (clk),
    .reset (reset),
    .req   (rq),
    .SCL   (SCL),
    .SDA   (SDA)
  );

  always #5 clk = ~clk;

  // Board pull-up plus slave open-drain driver.
  logic slv_low = 1'b0;
  pullup (SDA);
  assign SDA = slv_low ? 1'b0 : 1'bz;

  typedef struct {
    int       done_cyc;
    bit       nack;
    bit [7:0] led;
    int       nbytes;
    int       starts;
  } exp_t;

  exp_t     sb[$];
  bit [7:0] exp_bytes[$];
  bit [7:0] mon_bytes[$];
  bit [7:0] model_led = 8'h00;
  bit       ff_armed = 1'b0;
  int       n_vec = 0;
  int       n_fail = 0;
  int       cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Slave model / bus monitor, sampled mid-cycle.
  logic     prev_scl = 1'b1;
  logic     prev_sda = 1'b1;
  int       bitn = 0;
  int       byte_idx = 0;
  bit       in_ack = 1'b0;
  bit       addr_ok = 1'b0;
  bit [7:0] shreg = 8'h00;
  bit [7:0] led = 8'h00;
  int       start_cnt = 0;
  int       stop_cnt = 0;

  always @(negedge clk) begin
    if (!reset) begin
      prev_scl <= 1'b1;
      prev_sda <= 1'b1;
      bitn     <= 0;
      byte_idx <= 0;
      in_ack   <= 1'b0;
      addr_ok  <= 1'b0;
      slv_low  <= 1'b0;
    end else begin
      prev_scl <= SCL;
      prev_sda <= SDA;
      if (rq.req_valid && rq.req_ready) begin
        start_cnt <= 0;
        stop_cnt  <= 0;
        mon_bytes.delete();
      end
      if (SCL && prev_scl && prev_sda && !SDA) begin
        start_cnt <= start_cnt + 1;
        bitn      <= 0;
        byte_idx  <= 0;
        in_ack    <= 1'b0;
        addr_ok   <= 1'b0;
      end else if (SCL && prev_scl && !prev_sda && SDA) begin
        stop_cnt <= stop_cnt + 1;
      end else if (SCL && !prev_scl) begin
        if (bitn < 8) begin
          shreg <= {shreg[6:0], SDA};
          bitn  <= bitn + 1;
        end
      end else if (!SCL && prev_scl) begin
        if (bitn == 8 && !in_ack) begin
          mon_bytes.push_back(shreg);
          in_ack <= 1'b1;
          if (byte_idx == 0) begin
            addr_ok <= (shreg == 8'hAA) && !(ff_armed && start_cnt == 1);
            slv_low <= (shreg == 8'hAA) && !(ff_armed && start_cnt == 1);
          end else if (byte_idx == 1 && addr_ok) begin
            slv_low <= (shreg != 8'h3C);
            if (shreg != 8'h3C) led <= shreg;
          end
        end else if (in_ack) begin
          slv_low  <= 1'b0;
          in_ack   <= 1'b0;
          bitn     <= 0;
          byte_idx <= byte_idx + 1;
        end
      end
    end
  end

  // Reference: attempts, phases and bus bytes from the protocol rules.
  task automatic predict(input bit [6:0] a, input bit [7:0] d, input bit ff,
                         input int t, output exp_t e);
    int phases;
    int max_att;
    bit aok;
    phases  = 0;
    max_att = 1;
`ifdef I2C_NACK_RETRY_EN
    max_att = MR + 1;
`endif
    e.nack   = 1'b1;
    e.led    = model_led;
    e.nbytes = 0;
    e.starts = 0;
    for (int i = 0; i < max_att && e.nack; i++) begin
      e.starts++;
      exp_bytes.push_back({a, 1'b0});
      e.nbytes++;
      aok = (a == 7'h55) && !(ff && i == 0);
      if (!aok) begin
        phases += 11;
      end else begin
        exp_bytes.push_back(d);
        e.nbytes++;
        phases += 20;
        if (d != 8'h3C) begin
          e.nack = 1'b0;
          e.led  = d;
        end
      end
    end
    e.done_cyc = t + 1 + 4 * CD * phases;
  endtask

  always @(negedge clk) begin
    if (reset && rq.done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_fail++;
        $display("FAIL spurious_done: got done=1, expected no done (cycle %0d)", cyc);
      end else begin
        exp_t     e;
        bit [7:0] b;
        e = sb.pop_front();
        model_led = e.led;
        check("done_cycle", 32'(cyc), 32'(e.done_cyc));
        check("nack", 32'(rq.nack), 32'(e.nack));
        check("slave_led", 32'(led), 32'(e.led));
        check("busy_at_done", 32'(rq.busy), 32'd0);
        check("ready_at_done", 32'(rq.req_ready), 32'd1);
        check("start_count", 32'(start_cnt), 32'(e.starts));
        check("stop_count", 32'(stop_cnt), 32'(e.starts));
        check("byte_count", 32'(mon_bytes.size()), 32'(e.nbytes));
        for (int i = 0; i < e.nbytes; i++) begin
          b = (exp_bytes.size() != 0) ? exp_bytes.pop_front() : 8'h00;
          if (i < mon_bytes.size()) check("bus_byte", 32'(mon_bytes[i]), 32'(b));
        end
      end
    end
  end

  task automatic do_tx(input bit [6:0] a, input bit [7:0] d, input bit ff, input bit abort);
    int   t;
    int   vc;
    int   guard;
    exp_t e;
    @(posedge clk); #1;
    rq.req_valid = 1'b1;
    rq.req_addr  = a;
    rq.req_data  = d;
    ff_armed     = ff;
    vc           = cyc;
    guard        = 0;
    @(negedge clk);
    while (!rq.req_ready && guard < 20) begin
      guard++;
      @(negedge clk);
    end
    if (!rq.req_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      rq.req_valid = 1'b0;
      return;
    end
    t = cyc;
    check("accept_latency", 32'(t), 32'(vc));
    predict(a, d, ff, t, e);
    sb.push_back(e);
    @(posedge clk); #1;
    rq.req_addr = 7'($urandom);
    rq.req_data = 8'($urandom);
    @(negedge clk);
    check("busy_after_accept", 32'(rq.busy), 32'd1);
    check("ready_while_busy", 32'(rq.req_ready), 32'd0);
    if ($urandom_range(0, 2) == 0) begin
      repeat ($urandom_range(1, 30)) @(posedge clk);
      #1;
    end
    rq.req_valid = 1'b0;
    if (abort) begin
      while (cyc < t + 1 + 4 * CD * 12 + 2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort_scl", 32'(SCL), 32'd1);
      check("abort_sda", 32'(SDA), 32'd1);
      check("abort_busy", 32'(rq.busy), 32'd0);
      check("abort_ready", 32'(rq.req_ready), 32'd1);
      sb.delete();
      exp_bytes.delete();
      repeat (6) @(posedge clk);
      #1;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      return;
    end
    guard = 0;
    @(negedge clk);
    while (!rq.done && guard < 4000) begin
      guard++;
      @(negedge clk);
    end
    if (!rq.done) begin
      check("done_timeout", 32'd0, 32'd1);
      sb.delete();
      exp_bytes.delete();
    end
  endtask

  initial begin
    bit [6:0] ra;
    bit [7:0] rd;
    rq.req_valid = 1'b0;
    rq.req_addr  = 7'h00;
    rq.req_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_scl", 32'(SCL), 32'd1);
    check("rst_sda", 32'(SDA), 32'd1);
    check("rst_ready", 32'(rq.req_ready), 32'd1);
    check("rst_busy", 32'(rq.busy), 32'd0);
    check("rst_done", 32'(rq.done), 32'd0);
    check("rst_nack", 32'(rq.nack), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);

    do_tx(7'h55, 8'hA5, 1'b0, 1'b0);
    do_tx(7'h12, 8'h99, 1'b0, 1'b0);
    do_tx(7'h55, 8'h3C, 1'b0, 1'b0);
    do_tx(7'h55, 8'h5A, 1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      ra = ($urandom_range(0, 1) == 0) ? 7'h55 : 7'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? 8'h3C : 8'($urandom);
      do_tx(ra, rd, ($urandom_range(0, 3) == 0), 1'b0);
      if ($urandom_range(0, 1) == 0) repeat ($urandom_range(1, 5)) @(posedge clk);
    end
    do_tx(7'h55, 8'h77, 1'b0, 1'b1);
    do_tx(7'h55, 8'hC3, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
